// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: packs RATIO consecutive DATA_SIZE entries little-endian
// into one wide word on a valid/ready stream, with flush support for partial words.
module fifo_rd_packer #(
  parameter int DATA_SIZE = 8,
  parameter int RATIO     = 4,
  parameter int CNT_W     = 16
) (
  input  logic                          r_clk,
  input  logic                          r_rst_n,
  input  logic                          empty,
  output logic                          r_en,
  input  logic [DATA_SIZE-1:0]          r_data,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_SIZE*RATIO-1:0]    out_data,
  output logic [RATIO-1:0]              out_keep,
  output logic                          out_last,
  output logic [CNT_W-1:0]              word_count
);

  localparam int IW = $clog2(RATIO);
  localparam int FW = IW + 1;
  localparam logic [FW-1:0] FULL = FW'(RATIO);

  logic [FW-1:0]                r_fill;
  logic                         r_inflight;
  logic                         r_flush_pending;
  logic [DATA_SIZE-1:0]         r_lane [RATIO];

  logic                         w_pack_full;
  logic                         w_slot_free;
  logic                         w_xfer;
  logic                         w_flush_go;
  logic                         w_partial;
  logic                         w_load;
  logic [FW-1:0]                w_committed;
  logic [RATIO-1:0]             w_keep;
  logic [DATA_SIZE*RATIO-1:0]   w_word;

  always_comb begin
    w_pack_full = (r_fill == FULL);
    w_slot_free = !out_valid || out_ready;
    w_xfer      = w_pack_full && w_slot_free;
    w_committed = r_fill + FW'(r_inflight);
    // Flush resolves only once the in-flight entry has landed in its lane.
    w_flush_go  = r_flush_pending && !r_inflight && w_slot_free;
    w_partial   = w_flush_go && !w_pack_full && (r_fill != '0);
    w_load      = w_xfer || w_partial;
    r_en        = r_rst_n && !empty && !r_flush_pending &&
                  ((w_committed < FULL) || w_xfer);
    w_keep      = '0;
    w_word      = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      w_keep[i] = w_pack_full || (FW'(i) < r_fill);
      w_word[i*DATA_SIZE +: DATA_SIZE] = w_keep[i] ? r_lane[i] : '0;
    end
  end

  always_ff @(posedge r_clk) begin
    if (!r_rst_n) begin
      r_fill          <= '0;
      r_inflight      <= 1'b0;
      r_flush_pending <= 1'b0;
      out_valid       <= 1'b0;
      out_data        <= '0;
      out_keep        <= '0;
      out_last        <= 1'b0;
      word_count      <= '0;
      for (int unsigned i = 0; i < RATIO; i++) begin
        r_lane[i] <= '0;
      end
    end else begin
      r_inflight <= r_en;

      // An entry is never in flight while the pack is full, so the lane index fits.
      if (r_inflight) begin
        r_lane[r_fill[IW-1:0]] <= r_data;
      end

      if (w_load) begin
        r_fill <= '0;
      end else if (r_inflight) begin
        r_fill <= r_fill + FW'(1);
      end

      if (w_flush_go) begin
        r_flush_pending <= 1'b0;
      end else if (flush) begin
        r_flush_pending <= 1'b1;
      end

      if (w_load) begin
        out_valid <= 1'b1;
        out_data  <= w_word;
        out_keep  <= w_keep;
        out_last  <= r_flush_pending;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (out_valid && out_ready) begin
        word_count <= word_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: a small FIFO model feeds the read port and
// every handshaken word is queued and compared against hand-computed values.
module tb_fifo_rd_packer;

  localparam int DS = 8;
  localparam int RT = 4;
  localparam int CW = 16;

  logic            r_clk = 1'b0;
  logic            r_rst_n = 1'b0;
  logic            empty;
  logic            r_en;
  logic [DS-1:0]   r_data = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [DS*RT-1:0] out_data;
  logic [RT-1:0]   out_keep;
  logic            out_last;
  logic [CW-1:0]   word_count;

  fifo_rd_packer #(.DATA_SIZE(DS), .RATIO(RT), .CNT_W(CW)) dut (
    .r_clk      (r_clk),
    .r_rst_n    (r_rst_n),
    .empty      (empty),
    .r_en       (r_en),
    .r_data     (r_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .out_last   (out_last),
    .word_count (word_count)
  );

  always #5 r_clk = ~r_clk;

  // FIFO model: one-cycle read latency, hold_empty masks availability.
  logic [DS-1:0] mem [0:63];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          hold_empty = 1'b0;
  int            ren_cnt = 0;

  assign empty = hold_empty || (rd_ptr == wr_ptr);

  always @(posedge r_clk) begin
    if (r_en) begin
      r_data  <= mem[rd_ptr];
      rd_ptr  <= rd_ptr + 1;
      ren_cnt <= ren_cnt + 1;
    end
  end

  logic [DS*RT+RT:0] words [$];
  always @(posedge r_clk) begin
    if (r_rst_n && out_valid && out_ready) begin
      words.push_back({out_last, out_keep, out_data});
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [DS-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr++;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge r_clk);
  endtask

  task automatic wait_words(input string tag, input int n);
    int k;
    k = 0;
    while (words.size() < n && k < 60) begin
      @(negedge r_clk);
      k++;
    end
    check({tag, "_word_arrived"}, 64'(words.size() >= n), 64'd1);
  endtask

  task automatic wait_ren(input string tag, input int target);
    int k;
    k = 0;
    while (ren_cnt < target && k < 60) begin
      @(negedge r_clk);
      k++;
    end
    check({tag, "_reads_done"}, 64'(ren_cnt >= target), 64'd1);
  endtask

  task automatic check_word(input string tag, input logic [DS*RT-1:0] d,
                            input logic [RT-1:0] kp, input logic lst);
    logic [DS*RT+RT:0] w;
    if (words.size() == 0) begin
      check({tag, "_present"}, 64'd0, 64'd1);
    end else begin
      w = words.pop_front();
      check({tag, "_data"}, 64'(w[DS*RT-1:0]), 64'(d));
      check({tag, "_keep"}, 64'(w[DS*RT+RT-1:DS*RT]), 64'(kp));
      check({tag, "_last"}, 64'(w[DS*RT+RT]), 64'(lst));
    end
  endtask

  task automatic pulse_flush;
    flush = 1'b1;
    @(negedge r_clk);
    flush = 1'b0;
  endtask

  int base;
  int changed;

  initial begin
    // Reset state
    cycles(3);
    check("rst_r_en", 64'(r_en), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_keep", 64'(out_keep), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_count", 64'(word_count), 64'd0);
    r_rst_n = 1'b1;
    cycles(1);

    // 1: single full word
    push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
    wait_words("t1", 1);
    cycles(2);
    check_word("t1", 32'hD4C3B2A1, 4'hF, 1'b0);
    check("t1_count", 64'(word_count), 64'd1);
    check("t1_ren", 64'(ren_cnt), 64'd4);

    // 2: backpressure with both packs full
    out_ready = 1'b0;
    base = ren_cnt;
    for (int i = 1; i <= 8; i++) push(DS'(i));
    cycles(20);
    check("t2_ren8", 64'(ren_cnt - base), 64'd8);
    push(8'h09);
    changed = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge r_clk);
      if (out_data !== 32'h04030201 || out_valid !== 1'b1 || r_en !== 1'b0) changed++;
    end
    check("t2_stall_stable", 64'(changed), 64'd0);
    check("t2_empty_low", 64'(empty), 64'd0);
    out_ready = 1'b1;
    wait_words("t2", 2);
    check_word("t2a", 32'h04030201, 4'hF, 1'b0);
    check_word("t2b", 32'h08070605, 4'hF, 1'b0);
    check("t2_count", 64'(word_count), 64'd3);
    cycles(3);
    pulse_flush();
    wait_words("t2f", 1);
    check_word("t2f", 32'h00000009, 4'b0001, 1'b1);

    // 3: partial flush of two lanes
    base = ren_cnt;
    push(8'h11); push(8'h22);
    wait_ren("t3", base + 2);
    cycles(2);
    hold_empty = 1'b1;
    push(8'h33);
    pulse_flush();
    hold_empty = 1'b0;
    #1;
    check("t3_no_ren_pending", 64'(r_en), 64'd0);
    wait_words("t3", 1);
    check_word("t3", 32'h00002211, 4'b0011, 1'b1);
    cycles(4);
    pulse_flush();
    wait_words("t3d", 1);
    check_word("t3d", 32'h00000033, 4'b0001, 1'b1);
    cycles(2);
    check("t3_count", 64'(word_count), 64'd6);

    // 4: flush with nothing packed
    hold_empty = 1'b1;
    push(8'h44);
    pulse_flush();
    hold_empty = 1'b0;
    #1;
    check("t4_blocked", 64'(r_en), 64'd0);
    @(negedge r_clk);
    check("t4_resume", 64'(r_en), 64'd1);
    check("t4_no_valid", 64'(out_valid), 64'd0);
    check("t4_count", 64'(word_count), 64'd6);
    push(8'h55); push(8'h66); push(8'h77);
    wait_words("t4", 1);
    check_word("t4", 32'h77665544, 4'hF, 1'b0);

    // 5: empty gap mid-word
    base = ren_cnt;
    push(8'h5A); push(8'h6B);
    wait_ren("t5", base + 2);
    hold_empty = 1'b1;
    push(8'h7C); push(8'h8D);
    #1;
    changed = 0;
    for (int i = 0; i < 3; i++) begin
      if (r_en !== 1'b0) changed++;
      @(negedge r_clk);
    end
    check("t5_gap_no_ren", 64'(changed), 64'd0);
    hold_empty = 1'b0;
    wait_words("t5", 1);
    check_word("t5", 32'h8D7C6B5A, 4'hF, 1'b0);
    cycles(2);
    check("t5_count", 64'(word_count), 64'd8);

    // 6: reset mid-word discards partial lanes
    base = ren_cnt;
    push(8'hAA); push(8'hBB);
    wait_ren("t6", base + 2);
    cycles(2);
    r_rst_n = 1'b0;
    push(8'h01);
    #1;
    check("t6_ren_in_rst", 64'(r_en), 64'd0);
    @(negedge r_clk);
    check("t6_ren_rst", 64'(r_en), 64'd0);
    check("t6_valid_rst", 64'(out_valid), 64'd0);
    check("t6_data_rst", 64'(out_data), 64'd0);
    check("t6_keep_rst", 64'(out_keep), 64'd0);
    check("t6_last_rst", 64'(out_last), 64'd0);
    check("t6_count_rst", 64'(word_count), 64'd0);
    r_rst_n = 1'b1;
    push(8'h02); push(8'h03); push(8'h04);
    wait_words("t6", 1);
    cycles(2);
    check_word("t6", 32'h04030201, 4'hF, 1'b0);
    check("t6_count", 64'(word_count), 64'd1);
    check("no_extra_words", 64'(words.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
